// File: rtl/hermes_route_arbiter.sv
// hermes_route_arbiter
//   Routing/allocation controller of a Hermes router. Round-robin arbitration
//   over the input buffers' routing requests, XY routing of the winner's head
//   flit, output allocation, and the input<->output connection tables that
//   steer the crossbar. A connection is torn down when its input's sending
//   flag falls.
//
//   Optional feature: define HERMES_ARB_LOCAL_PRIO_EN to give a pending LOCAL
//   request absolute priority in IDLE. Without it, the winner is chosen by
//   pure round-robin.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   req_i       routing request per input, held until its req_ack_o pulse
//   header_i    head flit per input; target X = [15:8], Y = [7:0]
//   sending_i   per-input payload-in-progress flag
//   req_ack_o   one-cycle grant pulse to the selected input
//   out_busy_o  output allocated
//   out_sel_o   input index feeding each output (valid when busy)
//   in_busy_o   input connected
//   in_sel_o    output index each input drives (valid when busy)
//   Port index map: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
module hermes_route_arbiter #(
    parameter int unsigned NPORT     = 5,
    parameter int unsigned FLIT_SIZE = 32,
    parameter logic [15:0] ADDRESS   = 16'h0000
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NPORT-1:0]                    req_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0]     header_i,
    input  logic [NPORT-1:0]                    sending_i,
    output logic [NPORT-1:0]                    req_ack_o,
    output logic [NPORT-1:0]                    out_busy_o,
    output logic [NPORT-1:0][2:0]               out_sel_o,
    output logic [NPORT-1:0]                    in_busy_o,
    output logic [NPORT-1:0][2:0]               in_sel_o
);

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    localparam logic [7:0] ADDR_X = ADDRESS[15:8];
    localparam logic [7:0] ADDR_Y = ADDRESS[7:0];

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ROUTE = 3'b010,
        GRANT = 3'b100
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [2:0]             winner_q, winner_d;
    logic [2:0]             dest_q, dest_d;
    logic [NPORT-1:0]       sending_q;
    logic [NPORT-1:0]       out_busy_q, out_busy_d;
    logic [NPORT-1:0][2:0]  out_sel_q, out_sel_d;
    logic [NPORT-1:0]       in_busy_q, in_busy_d;
    logic [NPORT-1:0][2:0]  in_sel_q, in_sel_d;

    logic [2:0]             pick;
    logic [2:0]             route;
    logic                   grant;
    logic [7:0]             tx, ty;
    logic                   hdr_unused;

    // Only the 16 address bits of the head flit take part in routing.
    assign hdr_unused = ^header_i;

    // First requester at or above the pointer, wrapping modulo NPORT.
    always_comb begin
        int unsigned slot;
        logic        found;
        pick  = '0;
        found = 1'b0;
        slot  = 0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            slot = 32'(ptr_q) + k;
            if (slot >= NPORT) slot = slot - NPORT;
            if (!found && req_i[3'(slot)]) begin
                pick  = 3'(slot);
                found = 1'b1;
            end
        end
`ifdef HERMES_ARB_LOCAL_PRIO_EN
        if (req_i[LOCAL]) pick = LOCAL;
`endif
    end

    // XY routing: resolve X first, then Y, unsigned 8-bit compares.
    always_comb begin
        tx = header_i[winner_q][15:8];
        ty = header_i[winner_q][7:0];
        if (tx > ADDR_X)      route = EAST;
        else if (tx < ADDR_X) route = WEST;
        else if (ty > ADDR_Y) route = NORTH;
        else if (ty < ADDR_Y) route = SOUTH;
        else                  route = LOCAL;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        dest_d    = dest_q;
        grant     = 1'b0;
        req_ack_o = '0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    winner_d = pick;
                    state_d  = ROUTE;
                end
            end
            ROUTE: begin
                dest_d  = route;
                state_d = GRANT;
            end
            GRANT: begin
                // Registered busy bit: a release on this same edge is not
                // visible yet, so the request is simply retried next pass.
                if (!out_busy_q[dest_q]) begin
                    grant               = 1'b1;
                    req_ack_o[winner_q] = 1'b1;
                end
                ptr_d   = (winner_q == 3'(NPORT - 1)) ? '0 : winner_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Connection tables: releases first, then a new grant. A grant never
    // targets an output being released, since it requires that output free.
    always_comb begin
        out_busy_d = out_busy_q;
        out_sel_d  = out_sel_q;
        in_busy_d  = in_busy_q;
        in_sel_d   = in_sel_q;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (sending_q[i] && !sending_i[i] && in_busy_q[i]) begin
                in_busy_d[i]              = 1'b0;
                out_busy_d[in_sel_q[i]]   = 1'b0;
            end
        end
        if (grant) begin
            out_busy_d[dest_q]  = 1'b1;
            out_sel_d[dest_q]   = winner_q;
            in_busy_d[winner_q] = 1'b1;
            in_sel_d[winner_q]  = dest_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            dest_q     <= '0;
            sending_q  <= '0;
            out_busy_q <= '0;
            out_sel_q  <= '0;
            in_busy_q  <= '0;
            in_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            dest_q     <= dest_d;
            sending_q  <= sending_i;
            out_busy_q <= out_busy_d;
            out_sel_q  <= out_sel_d;
            in_busy_q  <= in_busy_d;
            in_sel_q   <= in_sel_d;
        end
    end

    assign out_busy_o = out_busy_q;
    assign out_sel_o  = out_sel_q;
    assign in_busy_o  = in_busy_q;
    assign in_sel_o   = in_sel_q;

endmodule

// File: doc/hermes_route_arbiter.md
# hermes_route_arbiter

Central routing and allocation controller of a Hermes router. It arbitrates round-robin among the routing requests raised by the NPORT input buffers and computes each packet's output port with XY routing from the header flit. It grants the request when that output is free and keeps the input↔output connection tables that drive the crossbar. A connection is released when the owning buffer stops sending, i.e. after the EOP flit has been transferred.

## Interface
- NPORT, 5, number of router ports; index map EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4
- FLIT_SIZE, 32, flit width; minimum 20
- ADDRESS, 16'h0000, this router's address; X = ADDRESS[15:8], Y = ADDRESS[7:0]

- clk_i  in  1  clock; single clock domain, all logic on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  NPORT  routing request per input buffer; held high until the matching req_ack_o pulse
- header_i  in  NPORT×FLIT_SIZE  head flit of each buffer (buffer data_o); target X = [15:8], Y = [7:0]
- sending_i  in  NPORT  per-input "payload in progress" flag (buffer sending_o)
- req_ack_o  out  NPORT  one-cycle grant pulse to the selected input
- out_busy_o  out  NPORT  output port allocated
- out_sel_o  out  NPORT×3  input index feeding each output; valid when out_busy_o set
- in_busy_o  out  NPORT  input port connected
- in_sel_o  out  NPORT×3  output index each input is connected to; valid when in_busy_o set

## Operation
- FSM, one-hot: IDLE, ROUTE, GRANT
- IDLE: if any req_i is set, register the winner. The winner is the first set bit searching upward from the pointer, modulo NPORT. Go to ROUTE. If no req_i is set, stay in IDLE.
- ROUTE: compute the destination from header_i[winner] and register it:
  - tx > X → EAST
  - tx < X → WEST
  - else ty > Y → NORTH
  - else ty < Y → SOUTH
  - else LOCAL
- Comparisons are unsigned, 8 bits each. Go to GRANT.
- GRANT, destination free (registered out_busy_o[dest] = 0):
  - pulse req_ack_o[winner] for this cycle only
  - on the next edge, set out_busy_o[dest], out_sel_o[dest]=winner, in_busy_o[winner], in_sel_o[winner]=dest
- GRANT, destination busy: no ack; the request is retried on a later pass.
- Leaving GRANT: in both cases, set the pointer to winner+1 (wrapping NPORT-1 → 0) and go to IDLE.
- Release: track sending_i with a one-cycle delayed copy, sending_q. For each input i, a falling edge (sending_q[i] & ~sending_i[i]) while in_busy_o[i] clears in_busy_o[i] and out_busy_o[in_sel_o[i]] on that edge.
  - Release works independently of FSM state.
  - Several releases may happen in the same cycle.
- Index fields of freed entries keep their old value.
- LOCAL→LOCAL connections are legal. Inputs whose in_busy_o is set are not excluded from arbitration.
  - A well-behaved buffer does not request while it is sending.

## Timing
- Reset values: req_ack_o=0, out_busy_o=0, in_busy_o=0, out_sel_o=0, in_sel_o=0; state=IDLE, pointer=0, sending_q=0.
- Reset asserted mid-operation drops all connections and any pending grant immediately.
- Request to ack: req_i seen in IDLE at cycle t gives req_ack_o at t+2 when the output is free. Tables update at t+3.
- Arbitration pass is 3 cycles; back-to-back passes are allowed, so IDLE at t+3 can evaluate the next request.
- Buffer sending_o rises at t+3 and its eventual fall frees the output at the following edge. That output can then be granted in a GRANT cycle one cycle later, at the earliest.
- Release and grant in the same cycle:
  - GRANT sees the registered busy bit, so it is denied and retried.
  - The release still takes effect.
- Simultaneous requests on all ports: each is served within NPORT passes once its output is free. No starvation under round-robin.

## Configuration
- HERMES_ARB_LOCAL_PRIO_EN defined: in IDLE, a set req_i[LOCAL] wins unconditionally. The pointer is still set to LOCAL+1 wrapped, i.e. 0.
- Not defined: pure round-robin as above.

## Test plan
- Reset release with ADDRESS=16'h0101, req_i[WEST]=1, header X=3 Y=1 → req_ack_o[WEST] pulses at t+2 for 1 cycle; at t+3 out_busy_o[EAST]=1, out_sel_o[EAST]=1, in_sel_o[WEST]=0.
- All five req_i high, each heading to a distinct output, pointer=0 → acks in order 0,1,2,3,4, spaced 3 cycles apart.
- Two inputs both targeting LOCAL (header 16'h0101):
  - first is granted; second gets no ack while sending_i[first]=1
  - after sending_i[first] falls, second is acked within 4 cycles
- sending_i falls on the same edge a GRANT for that output is evaluated → no ack that pass; the output is freed; the next pass acks.
- rst_ni pulled low for 1 cycle with 3 connections live → all busy bits 0 asynchronously; no req_ack_o pulse emitted.
- With HERMES_ARB_LOCAL_PRIO_EN defined, pointer=0, req_i=5'b10001 → LOCAL acked first; without the macro, EAST acked first.
